rgb_pwm_sequencer: RTL and testbench

Parametrised tri-colour LED driver and the next generation of the fixed R/G/B colour cycler. It walks a palette of up to 8 colours and drives R, G and B as PWM outputs with per-channel brightness. Three modes are supported: hard step, linear crossfade and manual advance. The top level instantiates it between the board clock/reset and the LED pins.

---
 rtl/rgb_seq_pkg.sv | 42 ++++
 rtl/pwm_channel.sv | 39 +++
 rtl/rgb_pwm_sequencer.sv | 174 +++++++++++++++++
 tb/tb_rgb_pwm_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared mode codes, sequencer state type and the fixed 8-entry colour palette
// for the RGB PWM sequencer.
package rgb_seq_pkg;

    localparam logic [1:0] MODE_STEP   = 2'd0;
    localparam logic [1:0] MODE_FADE   = 2'd1;
    localparam logic [1:0] MODE_MANUAL = 2'd2;

    typedef enum logic {
        HOLD = 1'b0,
        FADE = 1'b1
    } seq_state_e;

    function automatic logic [23:0] palette_rgb(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = 24'hFF0000;
            3'd1:    rgb = 24'h00FF00;
            3'd2:    rgb = 24'h0000FF;
            3'd3:    rgb = 24'hFFFF00;
            3'd4:    rgb = 24'h00FFFF;
            3'd5:    rgb = 24'hFF00FF;
            3'd6:    rgb = 24'hFFFFFF;
            default: rgb = 24'h000000;
        endcase
        return rgb;
    endfunction

    // Channel 0 is red, 1 is green, 2 is blue.
    function automatic logic [7:0] palette_byte(input logic [2:0] idx, input logic [1:0] ch);
        logic [23:0] rgb;
        logic [7:0]  b;
        rgb = palette_rgb(idx);
        case (ch)
            2'd0:    b = rgb[23:16];
            2'd1:    b = rgb[15:8];
            default: b = rgb[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: duty is latched from the level only at the period boundary,
// so level changes never cut a period short or stretch it.
module pwm_channel #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] level,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic                out_q;
    logic                out_d;

    // At the boundary the freshly latched duty already governs count zero.
    always_comb begin
        duty_d = duty_q;
        if (pwm_cnt == '0) begin
            duty_d = level;
        end
        out_d = (pwm_cnt < duty_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q <= '0;
            out_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            out_q  <= out_d;
        end
    end

    assign pwm_out = out_q;

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Walks the colour palette in STEP, FADE or MANUAL mode and drives R/G/B
// through three boundary-latched PWM channels.
module rgb_pwm_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int TICK_DIV   = 100000,
    parameter int HOLD_TICKS = 500,
    parameter int NUM_COLORS = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] mode,
    input  logic       pause,
    input  logic       next,
    output logic       R,
    output logic       G,
    output logic       B,
    output logic [2:0] color_idx,
    output logic       step_done
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [2:0]          IDX_LAST  = 3'(NUM_COLORS - 1);

    typedef logic [2:0][PWM_BITS-1:0] levels_t;

    function automatic levels_t color_levels(input logic [2:0] idx);
        levels_t lv;
        for (int c = 0; c < 3; c++) begin
            lv[c] = PWM_BITS'(palette_byte(idx, 2'(c)) >> (8 - PWM_BITS));
        end
        return lv;
    endfunction

    function automatic logic [2:0] next_index(input logic [2:0] idx);
        return (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    endfunction

    logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q,  tick_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
    seq_state_e          state_q,     state_d;
    logic [2:0]          color_idx_q, color_idx_d;
    levels_t             lvl_q,       lvl_d;
    levels_t             tgt_q,       tgt_d;
    logic                step_done_q, step_done_d;
    logic                tick;
    levels_t             faded;
    logic [2:0]          idx_inc;

    always_comb begin
        pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);

        tick       = !pause && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (!pause) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        end

        faded = lvl_q;
        for (int c = 0; c < 3; c++) begin
            if (tick && (lvl_q[c] < tgt_q[c])) begin
                faded[c] = lvl_q[c] + PWM_BITS'(1);
            end else if (tick && (lvl_q[c] > tgt_q[c])) begin
                faded[c] = lvl_q[c] - PWM_BITS'(1);
            end
        end

        idx_inc     = next_index(color_idx_q);
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        color_idx_d = color_idx_q;
        lvl_d       = lvl_q;
        tgt_d       = tgt_q;
        step_done_d = 1'b0;

        case (state_q)
            HOLD: begin
                if (tick) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        case (mode)
                            MODE_STEP: begin
                                color_idx_d = idx_inc;
                                lvl_d       = color_levels(idx_inc);
                                step_done_d = 1'b1;
                            end
                            MODE_FADE: begin
                                state_d = FADE;
                                tgt_d   = color_levels(idx_inc);
                            end
                            default: ;
                        endcase
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                // Reserved mode 3 shares MODE_MANUAL's top bit; the tick path
                // above never advances in these modes, so one advance at most.
                if (next && mode[1]) begin
                    hold_cnt_d  = '0;
                    color_idx_d = idx_inc;
                    lvl_d       = color_levels(idx_inc);
                    step_done_d = 1'b1;
                end
            end
            FADE: begin
                lvl_d = faded;
                if (faded == tgt_q) begin
                    state_d     = HOLD;
                    hold_cnt_d  = '0;
                    color_idx_d = idx_inc;
                    step_done_d = 1'b1;
                end
            end
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pwm_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            state_q     <= HOLD;
            color_idx_q <= 3'd0;
            lvl_q       <= color_levels(3'd0);
            tgt_q       <= '0;
            step_done_q <= 1'b0;
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            state_q     <= state_d;
            color_idx_q <= color_idx_d;
            lvl_q       <= lvl_d;
            tgt_q       <= tgt_d;
            step_done_q <= step_done_d;
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_r (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .pwm_cnt (pwm_cnt_q),
        .level   (lvl_q[0]),
        .pwm_out (R)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_g (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .pwm_cnt (pwm_cnt_q),
        .level   (lvl_q[1]),
        .pwm_out (G)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_b (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .pwm_cnt (pwm_cnt_q),
        .level   (lvl_q[2]),
        .pwm_out (B)
    );

    assign color_idx = color_idx_q;
    assign step_done = step_done_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench for rgb_pwm_sequencer with PWM_BITS=4, TICK_DIV=2,
// HOLD_TICKS=3, NUM_COLORS=8; cycle numbers count edges after reset release.
module tb_rgb_pwm_sequencer;
    import rgb_seq_pkg::*;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [1:0] mode      = MODE_STEP;
    logic       pause     = 1'b0;
    logic       next      = 1'b0;
    logic       R, G, B;
    logic [2:0] color_idx;
    logic       step_done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int r_hi, g_hi, b_hi;
    int sd_cnt, sd_cyc;
    logic [2:0] seq[$];

    rgb_pwm_sequencer #(
        .PWM_BITS   (4),
        .TICK_DIV   (2),
        .HOLD_TICKS (3),
        .NUM_COLORS (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mode      (mode),
        .pause     (pause),
        .next      (next),
        .R         (R),
        .G         (G),
        .B         (B),
        .color_idx (color_idx),
        .step_done (step_done)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic p, input logic n);
        mode  = m;
        pause = p;
        next  = n;
    endtask

    task automatic clearCounts();
        r_hi = 0;
        g_hi = 0;
        b_hi = 0;
    endtask

    // Each call advances one edge per iteration and samples 1 time unit later.
    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
            cyc++;
            r_hi += int'(R);
            g_hi += int'(G);
            b_hi += int'(B);
            if (step_done) begin
                sd_cnt++;
                sd_cyc = cyc;
                seq.push_back(color_idx);
            end
        end
    endtask

    task automatic doReset(input logic [1:0] m);
        sys_rst_n = 1'b0;
        applyStimulus(m, 1'b0, 1'b0);
        runCycles(3);
        sys_rst_n = 1'b1;
        cyc    = 0;
        sd_cnt = 0;
        sd_cyc = -1;
        seq.delete();
        clearCounts();
    endtask

    initial begin
        #1;
        // Scenario 1: reset values, then STEP from red to green.
        doReset(MODE_STEP);
        checkOutput("rst_idx", 32'(color_idx), 0);
        checkOutput("rst_rgb", 32'({R, G, B}), 0);
        checkOutput("rst_step_done", 32'(step_done), 0);
        runCycles(1);
        checkOutput("s1_first_r", 32'(R), 1);
        runCycles(6);
        checkOutput("s1_sd_cycle", sd_cyc, 6);
        checkOutput("s1_idx", 32'(color_idx), 1);
        checkOutput("s1_sd_single", 32'(step_done), 0);
        applyStimulus(MODE_MANUAL, 1'b0, 1'b0);
        runCycles(8);
        checkOutput("s1_p1_r", r_hi, 15);
        checkOutput("s1_p1_g", g_hi, 0);
        checkOutput("s1_p1_b", b_hi, 0);
        clearCounts();
        runCycles(15);
        checkOutput("s1_p2_r", r_hi, 0);
        checkOutput("s1_p2_g", g_hi, 15);
        checkOutput("s1_p2_b", b_hi, 0);
        checkOutput("s1_sd_cnt", sd_cnt, 1);

        // Scenario 2: STEP through the whole palette, pausing on black.
        doReset(MODE_STEP);
        while (sd_cnt < 7 && cyc < 60) runCycles(1);
        checkOutput("s2_idx7_cycle", cyc, 42);
        applyStimulus(MODE_STEP, 1'b1, 1'b0);
        runCycles(3);
        clearCounts();
        runCycles(15);
        checkOutput("s2_black_hi", r_hi + g_hi + b_hi, 0);
        checkOutput("s2_paused_idx", 32'(color_idx), 7);
        applyStimulus(MODE_STEP, 1'b0, 1'b0);
        runCycles(10);
        checkOutput("s2_sd_cycle", sd_cyc, 66);
        checkOutput("s2_sd_cnt", sd_cnt, 8);
        checkOutput("s2_wrap_idx", 32'(color_idx), 0);
        for (int i = 0; i < seq.size(); i++) begin
            checkOutput($sformatf("s2_seq%0d", i), 32'(seq[i]), (i + 1) % 8);
        end

        // Scenario 3: FADE red to green, duty per period.
        doReset(MODE_FADE);
        runCycles(15);
        checkOutput("s3_p1_r", r_hi, 15);
        checkOutput("s3_p1_g", g_hi, 0);
        clearCounts();
        runCycles(15);
        checkOutput("s3_p2_r", r_hi, 11);
        checkOutput("s3_p2_g", g_hi, 4);
        clearCounts();
        runCycles(15);
        checkOutput("s3_p3_r", r_hi, 3);
        checkOutput("s3_p3_g", g_hi, 12);
        checkOutput("s3_p3_b", b_hi, 0);
        checkOutput("s3_sd_cycle", sd_cyc, 36);
        checkOutput("s3_sd_cnt", sd_cnt, 1);
        checkOutput("s3_idx", 32'(color_idx), 1);

        // Scenario 4: pause mid-fade, then resume.
        doReset(MODE_FADE);
        runCycles(20);
        applyStimulus(MODE_FADE, 1'b1, 1'b0);
        runCycles(10);
        clearCounts();
        runCycles(30);
        checkOutput("s4_frozen_r", r_hi, 16);
        checkOutput("s4_frozen_g", g_hi, 14);
        checkOutput("s4_frozen_idx", 32'(color_idx), 0);
        checkOutput("s4_frozen_sd", sd_cnt, 0);
        applyStimulus(MODE_FADE, 1'b0, 1'b0);
        clearCounts();
        runCycles(15);
        checkOutput("s4_resume_r", r_hi, 8);
        checkOutput("s4_resume_g", g_hi, 7);
        runCycles(5);
        checkOutput("s4_sd_cycle", sd_cyc, 76);
        checkOutput("s4_idx", 32'(color_idx), 1);

        // Scenario 5: MANUAL advance, next under pause, next ignored in STEP.
        doReset(MODE_MANUAL);
        runCycles(200);
        checkOutput("s5_idle_idx", 32'(color_idx), 0);
        checkOutput("s5_idle_sd", sd_cnt, 0);
        applyStimulus(MODE_MANUAL, 1'b0, 1'b1);
        runCycles(1);
        checkOutput("s5_next_idx", 32'(color_idx), 1);
        checkOutput("s5_next_sd", 32'(step_done), 1);
        applyStimulus(MODE_MANUAL, 1'b0, 1'b0);
        runCycles(1);
        checkOutput("s5_sd_drop", 32'(step_done), 0);
        applyStimulus(MODE_MANUAL, 1'b1, 1'b1);
        runCycles(1);
        checkOutput("s5_pause_next_idx", 32'(color_idx), 2);
        applyStimulus(MODE_STEP, 1'b1, 1'b1);
        runCycles(1);
        applyStimulus(MODE_STEP, 1'b1, 1'b0);
        runCycles(2);
        checkOutput("s5_step_next_idx", 32'(color_idx), 2);
        checkOutput("s5_sd_cnt", sd_cnt, 2);

        // Scenario 6: reset in the middle of the blue-to-yellow fade.
        doReset(MODE_FADE);
        runCycles(85);
        checkOutput("s6_pre_idx", 32'(color_idx), 2);
        sys_rst_n = 1'b0;
        runCycles(1);
        checkOutput("s6_rst_idx", 32'(color_idx), 0);
        checkOutput("s6_rst_rgb", 32'({R, G, B}), 0);
        checkOutput("s6_rst_sd", 32'(step_done), 0);
        doReset(MODE_FADE);
        runCycles(15);
        checkOutput("s6_after_r", r_hi, 15);
        checkOutput("s6_after_g", g_hi, 0);
        checkOutput("s6_after_b", b_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
